// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and default widths for the MEM/WB stage
package cpu_pkg;

  localparam int DEFAULT_DATA_W     = 16;
  localparam int DEFAULT_REG_ADDR_W = 4;

  typedef enum logic [2:0] {
    WB_SEL_ALU = 3'b000,
    WB_SEL_MEM = 3'b001,
    WB_SEL_IMM = 3'b010
  } wb_sel_t;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } mws_state_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - data-memory load request/acknowledge port
interface mem_wb_stage_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) ();

  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with load completion and timeout
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int REG_ADDR_W  = DEFAULT_REG_ADDR_W,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [DATA_W-1:0]     ex_alu_result,
  input  logic [DATA_W-1:0]     ex_imm,
  input  logic [2:0]            ex_wb_sel,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  mem_wb_stage_if.master        mem,
  output logic                  wb_valid,
  output logic [DATA_W-1:0]     wb_data0,
  output logic [DATA_W-1:0]     wb_data1,
  output logic [DATA_W-1:0]     wb_data2,
  output logic [2:0]            wb_select,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_reg_write,
  output logic                  sel_err,
  output logic                  mem_err
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_WAIT = WAIT_MEM;

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic [DATA_W-1:0]     mem_addr_q, mem_addr_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]     wb_data0_q, wb_data0_d;
  logic [DATA_W-1:0]     wb_data1_q, wb_data1_d;
  logic [DATA_W-1:0]     wb_data2_q, wb_data2_d;
  logic [2:0]            wb_select_q, wb_select_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic                  wb_reg_write_q, wb_reg_write_d;
  logic                  sel_err_q, sel_err_d;
  logic                  mem_err_q, mem_err_d;

  // Load payload parked here so the wb outputs keep their last values until completion.
  logic [DATA_W-1:0]     pend_data0_q, pend_data0_d;
  logic [DATA_W-1:0]     pend_data2_q, pend_data2_d;
  logic [2:0]            pend_select_q, pend_select_d;
  logic [REG_ADDR_W-1:0] pend_rd_q, pend_rd_d;
  logic                  pend_rw_q, pend_rw_d;
  logic                  pend_sel_err_q, pend_sel_err_d;

  logic       sel_legal;
  logic [2:0] sel_clean;

  assign sel_legal = (ex_wb_sel == WB_SEL_ALU) || (ex_wb_sel == WB_SEL_MEM) ||
                     (ex_wb_sel == WB_SEL_IMM);
  assign sel_clean = sel_legal ? ex_wb_sel : WB_SEL_ALU;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mem_req_d      = mem_req_q;
    mem_addr_d     = mem_addr_q;
    wb_valid_d     = 1'b0;
    wb_data0_d     = wb_data0_q;
    wb_data1_d     = wb_data1_q;
    wb_data2_d     = wb_data2_q;
    wb_select_d    = wb_select_q;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = wb_reg_write_q;
    sel_err_d      = 1'b0;
    mem_err_d      = 1'b0;
    pend_data0_d   = pend_data0_q;
    pend_data2_d   = pend_data2_q;
    pend_select_d  = pend_select_q;
    pend_rd_d      = pend_rd_q;
    pend_rw_d      = pend_rw_q;
    pend_sel_err_d = pend_sel_err_q;

    if (flush) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      mem_req_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (ex_valid) begin
        if (ex_mem_read) begin
          pend_data0_d   = ex_alu_result;
          pend_data2_d   = ex_imm;
          pend_select_d  = sel_clean;
          pend_rd_d      = ex_rd;
          pend_rw_d      = ex_reg_write & sel_legal;
          pend_sel_err_d = ~sel_legal;
          mem_req_d      = 1'b1;
          mem_addr_d     = ex_alu_result;
          cnt_d          = CW'(1);
          state_d        = ST_WAIT;
        end else begin
          wb_valid_d     = 1'b1;
          wb_data0_d     = ex_alu_result;
          wb_data1_d     = '0;
          wb_data2_d     = ex_imm;
          wb_select_d    = sel_clean;
          wb_rd_d        = ex_rd;
          wb_reg_write_d = ex_reg_write & sel_legal;
          sel_err_d      = ~sel_legal;
        end
      end
    end else begin
      if (mem.mem_ack || (cnt_q == CW'(MEM_TIMEOUT))) begin
        // An ack landing on the final counted cycle still completes the load normally.
        wb_valid_d     = 1'b1;
        wb_data0_d     = pend_data0_q;
        wb_data1_d     = mem.mem_ack ? mem.mem_rdata : '0;
        wb_data2_d     = pend_data2_q;
        wb_select_d    = pend_select_q;
        wb_rd_d        = pend_rd_q;
        wb_reg_write_d = pend_rw_q & mem.mem_ack;
        sel_err_d      = pend_sel_err_q;
        mem_err_d      = ~mem.mem_ack;
        mem_req_d      = 1'b0;
        cnt_d          = '0;
        state_d        = ST_IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
      wb_valid_q     <= 1'b0;
      wb_data0_q     <= '0;
      wb_data1_q     <= '0;
      wb_data2_q     <= '0;
      wb_select_q    <= '0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      sel_err_q      <= 1'b0;
      mem_err_q      <= 1'b0;
      pend_data0_q   <= '0;
      pend_data2_q   <= '0;
      pend_select_q  <= '0;
      pend_rd_q      <= '0;
      pend_rw_q      <= 1'b0;
      pend_sel_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mem_req_q      <= mem_req_d;
      mem_addr_q     <= mem_addr_d;
      wb_valid_q     <= wb_valid_d;
      wb_data0_q     <= wb_data0_d;
      wb_data1_q     <= wb_data1_d;
      wb_data2_q     <= wb_data2_d;
      wb_select_q    <= wb_select_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      sel_err_q      <= sel_err_d;
      mem_err_q      <= mem_err_d;
      pend_data0_q   <= pend_data0_d;
      pend_data2_q   <= pend_data2_d;
      pend_select_q  <= pend_select_d;
      pend_rd_q      <= pend_rd_d;
      pend_rw_q      <= pend_rw_d;
      pend_sel_err_q <= pend_sel_err_d;
    end
  end

  assign ex_ready     = (state_q == ST_IDLE);
  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign wb_valid     = wb_valid_q;
  assign wb_data0     = wb_data0_q;
  assign wb_data1     = wb_data1_q;
  assign wb_data2     = wb_data2_q;
  assign wb_select    = wb_select_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_reg_write_q;
  assign sel_err      = sel_err_q;
  assign mem_err      = mem_err_q;

endmodule
